// File: rtl/ahb_sram_slave.sv
// AHB-lite SRAM slave: byte-lane strobes, programmable wait states,
// and write-to-read forwarding for back-to-back store/load.
module ahb_sram_slave #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [2:0]  hsize,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hready
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [2:0] CNT_INIT =
    3'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DATA
  } state_t;

  state_t state, state_n;
  logic [2:0] cnt, cnt_n;
  logic hready_n;

  logic [ADDR_WIDTH-1:0] idx_q, idx_a;
  logic [3:0] strb_q, strb_a;
  logic wr_q;
  logic accept, commit;
  logic [31:0] fwd;
  logic [31:0] mem [DEPTH];

  logic unused_bits;
  assign unused_bits = ^{haddr[31:ADDR_WIDTH+2], htrans[0]};

  assign accept = hsel & htrans[1] & hready;
  assign commit = (state == S_DATA) & wr_q;
  assign idx_a  = haddr[ADDR_WIDTH+1:2];

  // Misaligned accesses are silently aligned down.
  always_comb begin
    strb_a = 4'b1111;
    unique case (1'b1)
      (hsize == 3'd0): strb_a = 4'b0001 << haddr[1:0];
      (hsize == 3'd1): strb_a = haddr[1] ? 4'b1100 : 4'b0011;
      default:         strb_a = 4'b1111;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      S_WAIT: begin
        if (cnt == 3'd0) state_n = S_DATA;
        else             cnt_n   = cnt - 3'd1;
      end
      default: begin
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_n = S_WAIT;
            cnt_n   = CNT_INIT;
          end else begin
            state_n = S_DATA;
          end
        end else begin
          state_n = S_IDLE;
        end
      end
    endcase
    hready_n = (state_n != S_WAIT);
  end

  // A read accepted on the edge a write commits to the same word
  // sees the new bytes instead of the stale array contents.
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      if (commit && idx_q == idx_a && strb_q[b])
        fwd[8*b +: 8] = hwdata[8*b +: 8];
      else
        fwd[8*b +: 8] = mem[idx_a][8*b +: 8];
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state  <= S_IDLE;
      cnt    <= 3'd0;
      hready <= 1'b1;
      hrdata <= 32'h0;
      wr_q   <= 1'b0;
      idx_q  <= '0;
      strb_q <= 4'b0000;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      hready <= hready_n;
      if (accept) begin
        idx_q  <= idx_a;
        wr_q   <= hwrite;
        strb_q <= strb_a;
        if (!hwrite) hrdata <= fwd;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (!hreset && commit) begin
      for (int b = 0; b < 4; b++) begin
        if (strb_q[b]) mem[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

endmodule
